// File: rtl/rf_write_sched.sv
// rtl/rf_write_sched.sv - write-port arbiter/sequencer for the 8x16 register file (optional stats: RF_SCHED_STATS_EN)
module rf_write_sched #(
  parameter int          DW         = 16,
  parameter int          AW         = 3,
  parameter logic [AW-1:0] HI_ADDR  = 3'd7,
  parameter logic [AW-1:0] LO_ADDR  = 3'd6,
  parameter int          STARVE_MAX = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          WbValid,
  input  logic [AW-1:0] WbAddr,
  input  logic [DW-1:0] WbData,
  output logic          WbReady,
  input  logic          MdValid,
  input  logic [DW-1:0] MdHi,
  input  logic [DW-1:0] MdLo,
  output logic          MdReady,
  input  logic          DbgValid,
  input  logic [AW-1:0] DbgAddr,
  input  logic [DW-1:0] DbgData,
  output logic          DbgReady,
  output logic          RfWriteEn,
  output logic [AW-1:0] RfWaddr,
  output logic [DW-1:0] RfDataIn,
`ifdef RF_SCHED_STATS_EN
  output logic [15:0]   CoreStallCnt,
  output logic [15:0]   DbgStarveCnt,
`endif
  output logic          Busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MD_LO = 1'b1;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [0:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [7:0]    dbg_wait_q, dbg_wait_d;

  logic          starve;
  logic          wb_gnt, md_gnt, dbg_gnt;

  assign starve = (dbg_wait_q == STARVE_LIM);

  // One-hot grant: the single ready goes to the winning requester; nothing is granted during the lo beat or in reset
  always_comb begin
    wb_gnt  = 1'b0;
    md_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (Reset_n && (state_q == IDLE)) begin
      if (starve && DbgValid) begin
        dbg_gnt = 1'b1;
      end else if (WbValid) begin
        wb_gnt = 1'b1;
      end else if (MdValid) begin
        md_gnt = 1'b1;
      end else if (DbgValid) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign WbReady  = wb_gnt;
  assign MdReady  = md_gnt;
  assign DbgReady = dbg_gnt;

  // Next write-port contents and sequencer state; address/data hold when no write is issued
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (wb_gnt) begin
          we_d    = 1'b1;
          waddr_d = WbAddr;
          wdata_d = WbData;
        end else if (dbg_gnt) begin
          we_d    = 1'b1;
          waddr_d = DbgAddr;
          wdata_d = DbgData;
        end else if (md_gnt) begin
          // Lo word is captured now so the unit may move on once accepted
          we_d    = 1'b1;
          waddr_d = HI_ADDR;
          wdata_d = MdHi;
          lo_d    = MdLo;
          state_d = MD_LO;
        end
      end
      MD_LO: begin
        we_d    = 1'b1;
        waddr_d = LO_ADDR;
        wdata_d = lo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Debug wait counter: counts consecutive refused cycles, saturates at the starvation limit
  always_comb begin
    dbg_wait_d = dbg_wait_q;
    if (!DbgValid || dbg_gnt) begin
      dbg_wait_d = 8'd0;
    end else if (dbg_wait_q != STARVE_LIM) begin
      dbg_wait_d = dbg_wait_q + 8'd1;
    end
  end

  // Registered state and write-port outputs; reset abandons any pending lo beat immediately
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      dbg_wait_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      lo_q       <= lo_d;
      dbg_wait_q <= dbg_wait_d;
    end
  end

  assign RfWriteEn = we_q;
  assign RfWaddr   = waddr_q;
  assign RfDataIn  = wdata_q;
  assign Busy      = (state_q == MD_LO);

`ifdef RF_SCHED_STATS_EN
  logic [15:0] core_stall_q, core_stall_d;
  logic [15:0] dbg_starve_q, dbg_starve_d;

  // Saturating stall/starvation event counters
  always_comb begin
    core_stall_d = core_stall_q;
    dbg_starve_d = dbg_starve_q;
    if (WbValid && !wb_gnt && (core_stall_q != 16'hFFFF)) begin
      core_stall_d = core_stall_q + 16'd1;
    end
    if ((dbg_wait_d == STARVE_LIM) && (dbg_wait_q != STARVE_LIM) && (dbg_starve_q != 16'hFFFF)) begin
      dbg_starve_d = dbg_starve_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      core_stall_q <= 16'd0;
      dbg_starve_q <= 16'd0;
    end else begin
      core_stall_q <= core_stall_d;
      dbg_starve_q <= dbg_starve_d;
    end
  end

  assign CoreStallCnt = core_stall_q;
  assign DbgStarveCnt = dbg_starve_q;
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// tb/tb_rf_write_sched.sv - directed self-checking bench for rf_write_sched
module tb_rf_write_sched;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        WbValid = 1'b0;
  logic [2:0]  WbAddr = '0;
  logic [15:0] WbData = '0;
  logic        WbReady;
  logic        MdValid = 1'b0;
  logic [15:0] MdHi = '0;
  logic [15:0] MdLo = '0;
  logic        MdReady;
  logic        DbgValid = 1'b0;
  logic [2:0]  DbgAddr = '0;
  logic [15:0] DbgData = '0;
  logic        DbgReady;
  logic        RfWriteEn;
  logic [2:0]  RfWaddr;
  logic [15:0] RfDataIn;
  logic        Busy;
`ifdef RF_SCHED_STATS_EN
  logic [15:0] CoreStallCnt;
  logic [15:0] DbgStarveCnt;
`endif

  int checks = 0;
  int errors = 0;

  rf_write_sched dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData), .WbReady(WbReady),
    .MdValid(MdValid), .MdHi(MdHi), .MdLo(MdLo), .MdReady(MdReady),
    .DbgValid(DbgValid), .DbgAddr(DbgAddr), .DbgData(DbgData), .DbgReady(DbgReady),
    .RfWriteEn(RfWriteEn), .RfWaddr(RfWaddr), .RfDataIn(RfDataIn),
`ifdef RF_SCHED_STATS_EN
    .CoreStallCnt(CoreStallCnt), .DbgStarveCnt(DbgStarveCnt),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    WbValid = 0; MdValid = 0; DbgValid = 0;
    Reset_n = 0;
    tick();
    tick();
    Reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 0;
    WbValid = 1; MdValid = 1; DbgValid = 1;
    tick();
    checks++; if (RfWriteEn !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", RfWriteEn); end
    checks++; if (RfWaddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got=%0h exp=0", RfWaddr); end
    checks++; if (RfDataIn !== 16'h0) begin errors++; $display("FAIL reset_data got=%0h exp=0", RfDataIn); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", Busy); end
    checks++; if ({WbReady, MdReady, DbgReady} !== 3'b000) begin errors++; $display("FAIL reset_readies got=%b exp=000", {WbReady, MdReady, DbgReady}); end
    WbValid = 0; MdValid = 0; DbgValid = 0;
    Reset_n = 1;
    tick();
  endtask

  task automatic test_core_write();
    WbValid = 1; WbAddr = 3'd2; WbData = 16'h1234;
    #1;
    checks++; if (WbReady !== 1'b1) begin errors++; $display("FAIL core_ready got=%0h exp=1", WbReady); end
    tick();
    WbValid = 0;
    checks++; if (RfWriteEn !== 1'b1) begin errors++; $display("FAIL core_we got=%0h exp=1", RfWriteEn); end
    checks++; if (RfWaddr !== 3'd2) begin errors++; $display("FAIL core_waddr got=%0h exp=2", RfWaddr); end
    checks++; if (RfDataIn !== 16'h1234) begin errors++; $display("FAIL core_data got=%0h exp=1234", RfDataIn); end
    tick();
    checks++; if (RfWriteEn !== 1'b0) begin errors++; $display("FAIL core_we_drop got=%0h exp=0", RfWriteEn); end
    checks++; if ({RfWaddr, RfDataIn} !== {3'd2, 16'h1234}) begin errors++; $display("FAIL core_hold got=%0h/%0h exp=2/1234", RfWaddr, RfDataIn); end
  endtask

  task automatic test_md_sequence();
    MdValid = 1; MdHi = 16'hAAAA; MdLo = 16'h5555;
    #1;
    checks++; if ({WbReady, MdReady, DbgReady} !== 3'b010) begin errors++; $display("FAIL md_ready got=%b exp=010", {WbReady, MdReady, DbgReady}); end
    tick();
    MdValid = 0; MdLo = 16'hFFFF;
    WbValid = 1; WbAddr = 3'd1; WbData = 16'h0101;
    #1;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd7, 16'hAAAA}) begin errors++; $display("FAIL md_hi got=%0h/%0h/%0h exp=1/7/aaaa", RfWriteEn, RfWaddr, RfDataIn); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL md_busy got=%0h exp=1", Busy); end
    checks++; if (WbReady !== 1'b0) begin errors++; $display("FAIL md_core_blocked got=%0h exp=0", WbReady); end
    tick();
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd6, 16'h5555}) begin errors++; $display("FAIL md_lo got=%0h/%0h/%0h exp=1/6/5555", RfWriteEn, RfWaddr, RfDataIn); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL md_busy_clear got=%0h exp=0", Busy); end
    checks++; if (WbReady !== 1'b1) begin errors++; $display("FAIL md_core_after got=%0h exp=1", WbReady); end
    tick();
    WbValid = 0;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd1, 16'h0101}) begin errors++; $display("FAIL md_core_write got=%0h/%0h/%0h exp=1/1/0101", RfWriteEn, RfWaddr, RfDataIn); end
    tick();
  endtask

  task automatic test_back_to_back();
    WbValid = 1; WbAddr = 3'd0; WbData = 16'hC0C0;
    MdValid = 1; MdHi = 16'h1111; MdLo = 16'h2222;
    DbgValid = 1; DbgAddr = 3'd3; DbgData = 16'hD0D0;
    #1;
    checks++; if ({WbReady, MdReady, DbgReady} !== 3'b100) begin errors++; $display("FAIL b2b_first got=%b exp=100", {WbReady, MdReady, DbgReady}); end
    tick();
    WbValid = 0;
    #1;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd0, 16'hC0C0}) begin errors++; $display("FAIL b2b_core got=%0h/%0h/%0h exp=1/0/c0c0", RfWriteEn, RfWaddr, RfDataIn); end
    checks++; if ({WbReady, MdReady, DbgReady} !== 3'b010) begin errors++; $display("FAIL b2b_second got=%b exp=010", {WbReady, MdReady, DbgReady}); end
    tick();
    MdValid = 0;
    #1;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd7, 16'h1111}) begin errors++; $display("FAIL b2b_hi got=%0h/%0h/%0h exp=1/7/1111", RfWriteEn, RfWaddr, RfDataIn); end
    checks++; if (DbgReady !== 1'b0) begin errors++; $display("FAIL b2b_dbg_blocked got=%0h exp=0", DbgReady); end
    tick();
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd6, 16'h2222}) begin errors++; $display("FAIL b2b_lo got=%0h/%0h/%0h exp=1/6/2222", RfWriteEn, RfWaddr, RfDataIn); end
    checks++; if (DbgReady !== 1'b1) begin errors++; $display("FAIL b2b_dbg_ready got=%0h exp=1", DbgReady); end
    tick();
    DbgValid = 0;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd3, 16'hD0D0}) begin errors++; $display("FAIL b2b_dbg got=%0h/%0h/%0h exp=1/3/d0d0", RfWriteEn, RfWaddr, RfDataIn); end
    tick();
  endtask

  task automatic test_starvation();
    apply_reset();
    WbValid = 1; WbAddr = 3'd3; WbData = 16'h3333;
    DbgValid = 1; DbgAddr = 3'd4; DbgData = 16'h4444;
    for (int c = 1; c <= 8; c++) begin
      #1;
      checks++; if ({WbReady, DbgReady} !== 2'b10) begin errors++; $display("FAIL starve_wait%0d got=%b exp=10", c, {WbReady, DbgReady}); end
      tick();
    end
    #1;
    checks++; if ({WbReady, DbgReady} !== 2'b01) begin errors++; $display("FAIL starve_grant got=%b exp=01", {WbReady, DbgReady}); end
    tick();
    DbgValid = 0;
    #1;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd4, 16'h4444}) begin errors++; $display("FAIL starve_dbg_write got=%0h/%0h/%0h exp=1/4/4444", RfWriteEn, RfWaddr, RfDataIn); end
    checks++; if (WbReady !== 1'b1) begin errors++; $display("FAIL starve_core_resume got=%0h exp=1", WbReady); end
    tick();
    WbValid = 0;
`ifdef RF_SCHED_STATS_EN
    checks++; if (CoreStallCnt !== 16'd1) begin errors++; $display("FAIL stats_core_stall got=%0d exp=1", CoreStallCnt); end
    checks++; if (DbgStarveCnt !== 16'd1) begin errors++; $display("FAIL stats_dbg_starve got=%0d exp=1", DbgStarveCnt); end
`endif
    tick();
  endtask

  task automatic test_reset_mid_sequence();
    MdValid = 1; MdHi = 16'hBEEF; MdLo = 16'hCAFE;
    tick();
    MdValid = 0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%0h exp=1", Busy); end
    Reset_n = 0;
    #1;
    checks++; if ({RfWriteEn, Busy} !== 2'b00) begin errors++; $display("FAIL rmid_async got=%b exp=00", {RfWriteEn, Busy}); end
    tick();
    Reset_n = 1;
    tick();
    checks++; if ({RfWriteEn, RfWaddr} !== {1'b0, 3'd0}) begin errors++; $display("FAIL rmid_no_lo got=%0h/%0h exp=0/0", RfWriteEn, RfWaddr); end
    WbValid = 1; WbAddr = 3'd5; WbData = 16'h5A5A;
    #1;
    checks++; if (WbReady !== 1'b1) begin errors++; $display("FAIL rmid_core_ready got=%0h exp=1", WbReady); end
    tick();
    WbValid = 0;
    checks++; if ({RfWriteEn, RfWaddr, RfDataIn} !== {1'b1, 3'd5, 16'h5A5A}) begin errors++; $display("FAIL rmid_core_write got=%0h/%0h/%0h exp=1/5/5a5a", RfWriteEn, RfWaddr, RfDataIn); end
    tick();
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_md_sequence();
    test_back_to_back();
    test_starvation();
    test_reset_mid_sequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
